// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first (acc = acc*10 + digit).
// Optional macro BCD_CHECK_EN: flag nibbles > 9 via err and force bin_out to 0.
module bcd_to_binary #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           bin_out,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  state_t              state_q, state_d;
  logic [31:0]         acc_q, acc_d;
  logic [4*DIGITS-1:0] sr_q, sr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         bin_q, bin_d;
  logic                err_q, err_d;
  logic                bad_q, bad_d;

  logic [3:0]          nib;
  logic [31:0]         acc_next;
  logic                bad_next;

  assign nib      = sr_q[4*DIGITS-1 -: 4];
  assign acc_next = (acc_q << 3) + (acc_q << 1) + {28'd0, nib};

`ifdef BCD_CHECK_EN
  assign bad_next = bad_q | (nib > 4'd9);
`else
  assign bad_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    bad_d   = bad_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bcd_in;
          acc_d   = '0;
          bad_d   = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = acc_next;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + 4'd1;
        bad_d = bad_next;
        if (cnt_q == LAST) begin
          // bin_out/err only ever change here, so they hold between conversions
          bin_d   = bad_next ? 32'd0 : acc_next;
          err_d   = bad_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == CONV);
  assign done    = (state_q == DONE);
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: latency/value model checked every cycle plus directed literal checks.
module tb_bcd_to_binary;
  localparam int D = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [4*D-1:0]  bcd_in;
  logic            busy;
  logic            done;
  logic [31:0]     bin_out;
  logic            err;

  int tests  = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  bcd_to_binary #(.DIGITS(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .bin_out(bin_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value of a packed BCD word as sum(digit_i * 10^i), wrapped to 32 bits.
  function automatic void ref_conv(input logic [4*D-1:0] bcd, output logic [31:0] res,
                                   output logic e);
    longint v = 0;
    longint p = 1;
    logic [3:0] nb;
    e = 1'b0;
    for (int i = 0; i < D; i++) begin
      nb = bcd[4*i +: 4];
      v += longint'(nb) * p;
      p *= 10;
`ifdef BCD_CHECK_EN
      if (nb > 4'd9) e = 1'b1;
`endif
    end
    res = e ? 32'd0 : v[31:0];
  endfunction

  // Transaction-level model: an accepted start at edge t0 gives busy for D cycles,
  // done in the cycle after edge t0+D, and the next start accepted at edge t0+D+2.
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  logic [31:0] m_res = '0;
  logic        m_err = 1'b0;
  logic [31:0] exp_bin = '0;
  logic        exp_err = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      exp_bin  = '0;
      exp_err  = 1'b0;
    end else begin
      if (m_active && cyc == m_t0 + D) begin
        exp_bin = m_res;
        exp_err = m_err;
      end else if (m_active && cyc == m_t0 + D + 1) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_t0     = cyc;
        ref_conv(bcd_in, m_res, m_err);
      end
    end
    exp_busy = m_active && (cyc >= m_t0) && (cyc < m_t0 + D);
    exp_done = m_active && (cyc == m_t0 + D);
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", {31'd0, busy}, {31'd0, exp_busy});
      check("model done", {31'd0, done}, {31'd0, exp_done});
      check("model bin_out", bin_out, exp_bin);
      check("model err", {31'd0, err}, {31'd0, exp_err});
    end
  end

  task automatic wait_done(input int budget, output int nbusy, output bit ok);
    ok = 1'b0;
    nbusy = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic do_conv(input string name, input logic [31:0] bcd, input logic [31:0] xbin,
                         input logic xerr);
    int nb;
    bit ok;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = $urandom;
    wait_done(30, nb, ok);
    check({name, " done seen"}, {31'd0, ok}, 32'd1);
    check({name, " bin_out"}, bin_out, xbin);
    check({name, " err"}, {31'd0, err}, {31'd0, xerr});
    check({name, " busy cycles"}, nb, D);
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int nb;
    int n;
    int t[3];
    bit ok;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset bin_out", bin_out, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    do_conv("5086", 32'h0000_5086, 32'h0000_13DE, 1'b0);
    do_conv("99999999", 32'h9999_9999, 32'h05F5_E0FF, 1'b0);
    do_conv("zero", 32'h0000_0000, 32'h0000_0000, 1'b0);
    do_conv("one", 32'h0000_0001, 32'h0000_0001, 1'b0);

    // restart attempt during CONV must be ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 32'h0000_1234;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 32'h0000_9999;
    @(negedge clk);
    start  = 1'b0;
    wait_done(30, nb, ok);
    check("ignore done seen", {31'd0, ok}, 32'd1);
    check("ignore bin_out", bin_out, 32'd1234);
    count_dones(12, n);
    check("ignore extra dones", n, 0);
    do_conv("9999", 32'h0000_9999, 32'd9999, 1'b0);

    // reset at count=4 aborts the conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 32'h0000_5086;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort bin_out", bin_out, 32'd0);
    check("abort err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    count_dones(15, n);
    check("abort no done", n, 0);
    do_conv("42", 32'h0000_0042, 32'd42, 1'b0);

`ifdef BCD_CHECK_EN
    do_conv("invalid 1A", 32'h0000_001A, 32'd0, 1'b1);
`else
    do_conv("invalid 1A", 32'h0000_001A, 32'd20, 1'b0);
`endif

    // start held high: back-to-back conversions every D+2 cycles
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 32'h0000_0007;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (done) begin
        t[n] = i;
        check("b2b bin_out", bin_out, 32'd7);
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b done count", n, 3);
    if (n == 3) begin
      check("b2b spacing 1", t[1] - t[0], D + 2);
      check("b2b spacing 2", t[2] - t[1], D + 2);
    end
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential packed-BCD to binary converter, the inverse of the score binary-to-digit path.
- Takes a DIGITS-wide packed BCD word, e.g. a digit string held by the display or score logic, and produces its unsigned binary value.
- Processes one digit per clock, most-significant digit first, using acc = acc*10 + digit.
- Uses a start/busy/done handshake so the game-logic FSM can convert stored decimal scores back to binary for comparison and arithmetic.

Parameters:
- DIGITS, 8, number of BCD digits in bcd_in; legal range 1..9, so the result always fits in 32 bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit DIGITS-1 in the top nibble, digit 0 in [3:0].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out and err are valid.
- bin_out  output  32  binary result, zero-extended; held until the next done.
- err  output  1  invalid-digit flag, valid with done and held with bin_out.

Behaviour:
- Reset: rst_n low at a rising edge forces:
  - state=IDLE;
  - busy=0, done=0, bin_out=0, err=0;
  - internal accumulator, shift register and digit counter to 0.
- Reset low mid-conversion aborts it. No done is produced for the aborted request.
- States:
  - IDLE: busy=0, done=0. If start=1 at edge E0, capture bcd_in into a shift register, clear acc and the sticky error, set count=0, and go to CONV. busy=1 from E0.
  - CONV: at each edge, acc <= acc*10 + top nibble; shift the register left 4; count++. At the edge where count reaches DIGITS-1, load bin_out and err, then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle; next edge returns to IDLE.
- Latency:
  - start sampled at E0; DIGITS further edges E1..E_DIGITS perform accumulation.
  - done is high in the cycle following edge E_DIGITS; with DIGITS=8, done follows edge E8.
  - A new start is accepted at earliest the edge after done drops, so minimum period is DIGITS+2 cycles.
- Handshake rules:
  - start while busy=1 or in DONE is ignored; there is no queueing.
  - bcd_in is don't-care after E0 because the captured copy is used.
  - start held high continuously produces back-to-back conversions, each taking DIGITS+2 cycles.
- Arithmetic:
  - acc is 32 bits; acc*10 is computed as (acc<<3)+(acc<<1).
  - Results wrap modulo 2^32. Wrap is unreachable for valid BCD at DIGITS ≤ 9.
  - Maximum valid value at DIGITS=8 is 99,999,999 = 0x05F5E0FF.
- bin_out and err change only on the DONE transition, or on reset.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - Any nibble > 9 encountered in CONV sets a sticky error bit.
  - At completion, err=1 and bin_out is forced to 0.
  - Latency is unchanged.
- Undefined:
  - No digit check; err is tied 0.
  - Nibbles > 9 are accumulated by value, e.g. 0x1A gives 1*10+10 = 20.

Test Plan:
- Reset, then start with bcd_in=0x00005086 -> done after 8 accumulation edges; bin_out=5086 (0x000013DE), err=0; busy high for exactly 8 cycles.
- bcd_in=0x99999999 -> bin_out=0x05F5E0FF; bcd_in=0x00000000 -> bin_out=0; bcd_in=0x00000001 -> bin_out=1.
- Start 0x00001234, pulse start again and change bcd_in to 0x00009999 during CONV -> a single done with bin_out=1234. A fresh start after done drops gives 9999.
- Assert rst_n=0 for one cycle at count=4 of a conversion -> all outputs 0 next cycle, no done pulse. A following start of 0x00000042 -> bin_out=42.
- bcd_in=0x0000001A -> with BCD_CHECK_EN: err=1, bin_out=0. Without it: err=0, bin_out=20.
- start held high for 3 conversions of 0x00000007 -> done pulses exactly 10 cycles apart (DIGITS+2), each with bin_out=7.
